// File: rtl/noc_local_ni.sv
// Local network interface: packs core requests into {dest,src,data} flits for the router
// and filters/buffers ejected flits for the core. Optional parity via NI_PARITY_EN.
module noc_local_ni #(
  parameter int unsigned NODE_ID    = 1,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_dest,
  input  logic [DATA_W-1:0]   req_data,
  output logic                tx_valid,
  input  logic                tx_ready,
`ifdef NI_PARITY_EN
  output logic [DATA_W+8:0]   tx_flit,
  input  logic [DATA_W+8:0]   rx_flit,
  output logic                par_err,
`else
  output logic [DATA_W+7:0]   tx_flit,
  input  logic [DATA_W+7:0]   rx_flit,
`endif
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [3:0]          rsp_src,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                self_err,
  output logic                misroute_err,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count
);

`ifdef NI_PARITY_EN
  localparam int unsigned FLIT_W = DATA_W + 9;
`else
  localparam int unsigned FLIT_W = DATA_W + 8;
`endif
  localparam int unsigned BODY_W = DATA_W + 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RXE_W  = DATA_W + 4;
  localparam logic [3:0]  SELF   = 4'(NODE_ID - 1);

  // ---------------- TX path ----------------
  logic [FLIT_W-1:0] tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wp, tx_rp;
  logic [CNT_W-1:0]  tx_occ, tx_occ_next;
  logic [BODY_W-1:0] tx_body;
  logic [FLIT_W-1:0] tx_new;
  logic              req_fire, req_self, tx_enq, tx_pop;

  assign req_fire = req_valid & req_ready;
  assign req_self = (req_dest == SELF);
  assign tx_enq   = req_fire & ~req_self;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_body  = {req_dest, SELF, req_data};
`ifdef NI_PARITY_EN
  assign tx_new   = {^tx_body, tx_body};
`else
  assign tx_new   = tx_body;
`endif
  assign tx_occ_next = tx_occ + CNT_W'(tx_enq) - CNT_W'(tx_pop);
  assign tx_flit     = tx_mem[tx_rp];

  // Ready/valid flags are registered from next occupancy, so a pop never raises ready early.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_occ    <= '0;
      req_ready <= 1'b0;
      tx_valid  <= 1'b0;
      self_err  <= 1'b0;
      tx_count  <= '0;
    end else begin
      if (tx_enq) begin
        tx_mem[tx_wp] <= tx_new;
        tx_wp         <= tx_wp + PTR_W'(1);
      end
      if (tx_pop) tx_rp <= tx_rp + PTR_W'(1);
      tx_occ    <= tx_occ_next;
      req_ready <= (tx_occ_next != CNT_W'(FIFO_DEPTH));
      tx_valid  <= (tx_occ_next != '0);
      self_err  <= req_fire & req_self;
      tx_count  <= tx_count + 16'(tx_pop);
    end
  end

  // ---------------- RX path ----------------
  logic [RXE_W-1:0] rx_mem [2];
  logic             rx_wp, rx_rp;
  logic [1:0]       rx_occ, rx_occ_next;
  logic [3:0]       rx_dest;
  logic             rx_par_ok, rx_acc, rx_wr, rx_bad_dest, rx_rd;

  assign rx_dest = rx_flit[DATA_W+7:DATA_W+4];
`ifdef NI_PARITY_EN
  assign rx_par_ok = ~^rx_flit;
`else
  assign rx_par_ok = 1'b1;
`endif
  assign rx_acc      = rx_valid & rx_ready;
  assign rx_wr       = rx_acc & rx_par_ok & (rx_dest == SELF);
  assign rx_bad_dest = rx_acc & rx_par_ok & (rx_dest != SELF);
  assign rx_rd       = rsp_valid & rsp_ready;
  assign rx_occ_next = rx_occ + 2'(rx_wr) - 2'(rx_rd);
  assign rsp_src     = rx_mem[rx_rp][DATA_W+3:DATA_W];
  assign rsp_data    = rx_mem[rx_rp][DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_mem[0]    <= '0;
      rx_mem[1]    <= '0;
      rx_wp        <= 1'b0;
      rx_rp        <= 1'b0;
      rx_occ       <= '0;
      rx_ready     <= 1'b0;
      rsp_valid    <= 1'b0;
      misroute_err <= 1'b0;
      rx_count     <= '0;
    end else begin
      if (rx_wr) begin
        rx_mem[rx_wp] <= rx_flit[RXE_W-1:0];
        rx_wp         <= ~rx_wp;
      end
      if (rx_rd) rx_rp <= ~rx_rp;
      rx_occ       <= rx_occ_next;
      rx_ready     <= (rx_occ_next < 2'd2);
      rsp_valid    <= (rx_occ_next != 2'd0);
      misroute_err <= misroute_err | rx_bad_dest;
      rx_count     <= rx_count + 16'(rx_wr);
    end
  end

`ifdef NI_PARITY_EN
  // Sticky parity error; corrupted flits are never dest-checked or buffered.
  always_ff @(posedge clk) begin
    if (reset) par_err <= 1'b0;
    else       par_err <= par_err | (rx_acc & ~rx_par_ok);
  end
`endif

endmodule
